uart_tx_cfg: RTL

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_tx_cfg.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_cfg.sv
// UART transmitter with a small transmit FIFO and per-frame latched framing
// configuration (data width, optional parity, one or two stop bits).
module uart_tx_cfg #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          nReset,
  input  logic                          en,
  input  logic [DATA_BITS-1:0]          data,
  input  logic                          valid,
  output logic                          ready,
  input  logic                          parityEn,
  input  logic                          parityOdd,
  input  logic                          twoStop,
  output logic                          out,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 two_stop_q, two_stop_d;
  logic                 out_q, out_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;
  logic [PW-1:0]        level_q, level_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic                 empty_c;
  logic                 full_c;
  logic                 push_c;
  logic                 pop_c;
  logic                 frame_end_c;
  logic [DATA_BITS-1:0] head_c;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_c  = valid & ~full_c;
  assign head_c  = mem_q[rd_ptr_q[AW-1:0]];

  assign ready = ready_q;
  assign out   = out_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign level = level_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
    two_stop_d  = two_stop_q;
    out_d       = out_q;
    done_d      = 1'b0;
    pop_c       = 1'b0;
    frame_end_c = 1'b0;

    if (en) begin
      unique case (state_q)
        S_IDLE: begin
          if (!empty_c) pop_c = 1'b1;
        end
        S_START: begin
          state_d = S_DATA;
          out_d   = shift_q[0];
          cnt_d   = CW'(DATA_BITS - 1);
        end
        S_DATA: begin
          if (cnt_q != '0) begin
            shift_d = shift_q >> 1;
            out_d   = shift_q[1];
            cnt_d   = cnt_q - CW'(1);
          end else if (par_en_q) begin
            state_d = S_PARITY;
            out_d   = par_bit_q;
          end else begin
            state_d = S_STOP1;
            out_d   = 1'b1;
          end
        end
        S_PARITY: begin
          state_d = S_STOP1;
          out_d   = 1'b1;
        end
        S_STOP1: begin
          if (two_stop_q) state_d = S_STOP2;
          else            frame_end_c = 1'b1;
        end
        S_STOP2: begin
          frame_end_c = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // A finished frame chains straight into the next start bit when data waits.
    if (frame_end_c) begin
      done_d = 1'b1;
      if (!empty_c) begin
        pop_c = 1'b1;
      end else begin
        state_d = S_IDLE;
        out_d   = 1'b1;
      end
    end

    if (pop_c) begin
      state_d    = S_START;
      shift_d    = head_c;
      par_en_d   = parityEn;
      par_bit_d  = (^head_c) ^ parityOdd;
      two_stop_d = twoStop;
      out_d      = 1'b0;
    end

    wr_ptr_d = push_c ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_c  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    level_d  = wr_ptr_d - rd_ptr_d;
    ready_d  = (level_d != PW'(FIFO_DEPTH));
    busy_d   = (state_d != S_IDLE) | (level_d != '0);
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      out_q      <= 1'b1;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      out_q      <= out_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q[AW-1:0]] <= data;
  end

endmodule
